tiles_rom_fetch: RTL

TILES_ROM_FETCH -- requirements
Module: tiles_rom_fetch

---
 rtl/tmnt_pkg.sv | 24 ++
 rtl/tiles_rom_fetch.sv | 131 +++++++++++++
 2 files changed

// File: rtl/tmnt_pkg.sv
// Shared types and widths for the tile ROM fetch path between planes and SDRAM.
package tmnt_pkg;

    localparam int unsigned TILE_AW = 18;
    localparam int unsigned SDR_AW  = 24;
    localparam int unsigned SDR_DW  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StRecvLo,
        StRecvHi,
        StCommit
    } fetch_state_e;

    // 32-bit word address to SDRAM byte address, wrapping at 24 bits.
    function automatic logic [SDR_AW-1:0] tile_byte_addr(
        input logic [SDR_AW-1:0]  base,
        input logic [TILE_AW-1:0] addr
    );
        return base + {{(SDR_AW - TILE_AW - 2){1'b0}}, addr, 2'b00};
    endfunction

endpackage

// File: rtl/tiles_rom_fetch.sv
// Fetches one 32-bit tile ROM word as two 16-bit SDRAM beats and presents it atomically.
module tiles_rom_fetch
    import tmnt_pkg::*;
#(
    parameter logic [SDR_AW-1:0] BASE    = 24'h100000,
    parameter int unsigned       TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [TILE_AW-1:0] tiles_rom_addr,
    output logic [31:0]        tiles_rom_dout,
    output logic               sdr_req,
    output logic [SDR_AW-1:0]  sdr_addr,
    input  logic               sdr_ack,
    input  logic               sdr_valid,
    input  logic [SDR_DW-1:0]  sdr_data,
    output logic               busy,
    output logic               err
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    fetch_state_e       state_q, state_d;
    logic [TILE_AW-1:0] cur_addr_q;
    logic               line_valid_q;
    logic [CntW-1:0]    cnt_q;
    logic [SDR_DW-1:0]  lo_q, hi_q;
    logic [31:0]        dout_q;
    logic               err_q;

    logic fetch_needed;
    logic in_recv;
    logic timeout;

    assign fetch_needed = !line_valid_q || (tiles_rom_addr != cur_addr_q);
    assign in_recv      = (state_q == StRecvLo) || (state_q == StRecvHi);
    assign timeout      = in_recv && (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (fetch_needed) state_d = StIssue;
            StIssue:  if (sdr_ack) state_d = StRecvLo;
            StRecvLo: begin
                if (timeout) begin
                    state_d = StIdle;
                end else if (sdr_valid) begin
                    state_d = StRecvHi;
                end
            end
            StRecvHi: begin
                if (timeout) begin
                    state_d = StIdle;
                end else if (sdr_valid) begin
                    state_d = StCommit;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        sdr_req  = 1'b0;
        sdr_addr = '0;
        busy     = (state_q != StIdle);
        if (state_q == StIssue) begin
            sdr_req  = 1'b1;
            sdr_addr = tile_byte_addr(BASE, cur_addr_q);
        end
    end

    // Output word is written only from the fully assembled beats in StCommit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr_q   <= '0;
            line_valid_q <= 1'b0;
            cnt_q        <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            dout_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (fetch_needed) cur_addr_q <= tiles_rom_addr;
                end
                StIssue: begin
                    if (sdr_ack) cnt_q <= '0;
                end
                StRecvLo: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (timeout) begin
                        err_q        <= 1'b1;
                        line_valid_q <= 1'b0;
                    end else if (sdr_valid) begin
                        lo_q <= sdr_data;
                    end
                end
                StRecvHi: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (timeout) begin
                        err_q        <= 1'b1;
                        line_valid_q <= 1'b0;
                    end else if (sdr_valid) begin
                        hi_q <= sdr_data;
                    end
                end
                StCommit: begin
                    dout_q       <= {hi_q, lo_q};
                    line_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign tiles_rom_dout = dout_q;
    assign err            = err_q;

endmodule
